// File: rtl/ones_rank_select.sv
// ones_rank_select: bit-serial locator of the rank-th set bit in a vector.
// Scans the captured vector from LSB to MSB, one bit per clock. It reports the
// index of the rank-th one, whether that one exists, and how many ones were
// counted up to the point where the scan stopped.
module ones_rank_select #(
    parameter int inCount = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [inCount-1:0]        in_vec,
    input  logic [$clog2(inCount):0]  rank,
    output logic                      busy,
    output logic                      done,
    output logic                      found,
    output logic [$clog2(inCount)-1:0] pos,
    output logic [$clog2(inCount):0]  ones_seen
);

    localparam int outCount = $clog2(inCount);
    localparam logic [outCount-1:0] LAST_IDX = outCount'(inCount - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [inCount-1:0]    vec_q, vec_d;
    logic [outCount:0]     rank_q, rank_d;
    logic [outCount-1:0]   idx_q, idx_d;
    logic [outCount:0]     ones_q, ones_d;
    logic                  found_q, found_d;
    logic [outCount-1:0]   pos_q, pos_d;

    // Scan helpers: the bit under the cursor and the count including it.
    logic                  cur_bit;
    logic [outCount:0]     ones_inc;

    // State and datapath registers; everything clears on reset so a reset
    // mid-scan drops the operation without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            rank_q  <= '0;
            idx_q   <= '0;
            ones_q  <= '0;
            found_q <= 1'b0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            rank_q  <= rank_d;
            idx_q   <= idx_d;
            ones_q  <= ones_d;
            found_q <= found_d;
            pos_q   <= pos_d;
        end
    end

    // Next-state and next-datapath logic; results hold unless a start is
    // accepted or the scan updates them.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        rank_d   = rank_q;
        idx_d    = idx_q;
        ones_d   = ones_q;
        found_d  = found_q;
        pos_d    = pos_q;
        cur_bit  = vec_q[idx_q];
        ones_inc = ones_q + {{outCount{1'b0}}, cur_bit};

        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d   = in_vec;
                    rank_d  = rank;
                    idx_d   = '0;
                    ones_d  = '0;
                    found_d = 1'b0;
                    pos_d   = '0;
                    // Rank zero names no bit, so there is nothing to scan.
                    state_d = (rank == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                ones_d = ones_inc;
                if (cur_bit && (ones_inc == rank_q)) begin
                    found_d = 1'b1;
                    pos_d   = idx_q;
                    state_d = DONE;
                end else if (idx_q == LAST_IDX) begin
                    // Rank beyond the popcount: ones_seen ends as the full count.
                    found_d = 1'b0;
                    pos_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign found     = found_q;
    assign pos       = pos_q;
    assign ones_seen = ones_q;

endmodule

// File: doc/ones_rank_select.md
Name: ones_rank_select

Overview:
- Inverse companion to the population-count block. The popcount block answers "how many ones are in in_vec". This block answers "where is the k-th one in in_vec".
- It is a bit-serial scanner with a start/done handshake. It walks the captured vector from LSB to MSB, one bit per clock.
- Outputs: the index of the rank-th set bit, a found flag, and the running ones count.
- Used wherever a popcount result must be mapped back to a bit position, e.g. picking the n-th requester in a mask.

Parameters:
- inCount, 16, width of the input vector; must be >= 2.
- outCount, $clog2(inCount), derived, not overridden; sets the pos width (outCount bits) and the rank/ones_seen width (outCount+1 bits).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- in_vec  input  inCount  vector to scan; captured on the accepted start.
- rank  input  outCount+1  1-based rank of the set bit to locate; captured on the accepted start.
- busy  output  1  high while in SCAN or DONE.
- done  output  1  one-cycle completion pulse.
- found  output  1  rank-th one exists.
- pos  output  outCount  bit index of the rank-th one; 0 when not found.
- ones_seen  output  outCount+1  ones counted up to the stop point.

Behaviour:
- Reset (asynchronous on rst_n low):
  - state=IDLE.
  - busy, done, found, pos, ones_seen = 0.
  - Internal vector, rank and index registers = 0.
- IDLE:
  - start=1 at edge E0: capture in_vec and rank, set idx=0 and ones_seen=0, clear found and pos.
  - If the captured rank==0: go to DONE with found=0.
  - Otherwise: go to SCAN.
- SCAN (one bit per cycle):
  - Examine vec[idx].
  - If the bit is 1: ones_seen <= ones_seen+1.
  - Hit (bit==1 and ones_seen+1==rank): found<=1, pos<=idx, go to DONE.
  - Miss at the end (idx==inCount-1, no hit): found<=0, pos<=0, go to DONE.
  - Otherwise: idx<=idx+1, stay in SCAN.
- DONE:
  - done=1 for exactly this one cycle, then go to IDLE.
  - busy=1 in DONE, so start is not accepted in this cycle.
- Latency, counting edges from the accepted start edge E0:
  - Hit at bit p: done is high in the cycle after E(p+1).
  - Not found: done is high in the cycle after E(inCount).
  - rank==0: done is high in the cycle after E0.
- Result hold: found, pos and ones_seen hold their values after DONE until the next accepted start.
- start while busy=1: ignored. in_vec and rank changes during a scan have no effect.
- rank > popcount, including rank >= inCount+1:
  - Full scan, found=0.
  - ones_seen equals the total popcount. This is the intended popcount-equivalent mode.
- ones_seen width: outCount+1 bits, so the value inCount (all ones) fits without wrap.
- pos width: outCount bits. Index inCount-1 is the maximum and does not wrap.
- Reset asserted mid-scan: immediate return to the reset values. No done pulse. The next start after release behaves normally.
- start held high continuously: a new operation is accepted on the first IDLE cycle after each DONE.

Test Plan (inCount=16):
- in_vec=16'h00A4 (bits 2,5,7 set), rank=2 -> done in the cycle after E6; found=1, pos=5, ones_seen=2. With rank=3: pos=7, done after E8.
- in_vec=16'h0000, rank=1 -> done after E16; found=0, pos=0, ones_seen=0. With rank=0 on any vector: done after E0, found=0, ones_seen=0.
- in_vec=16'hFFFF, rank=16 -> found=1, pos=15, ones_seen=16, done after E16. With rank=17: found=0, ones_seen=16.
- Start in_vec=16'h8001, rank=2. At E3 pulse start with a new in_vec=16'h0001, rank=1, which must be ignored. Required: the original result found=1, pos=15, done after E16. The following start then uses the new inputs.
- Start a scan, assert rst_n low at E4 -> all outputs 0 immediately and no done pulse. After release, in_vec=16'h0010, rank=1 -> found=1, pos=4, done after E5.
- 1000 random vectors with rank=17 -> ones_seen equals the popcount block's count for the same vector, and found=0. For random rank in 1..16, pos equals the index of the rank-th set bit from a reference model.
